// File: rtl/add_sub_lanes_if.sv
// add_sub_lanes_if: handshake and data bundle between a producer/consumer and the add_sub_lanes pipeline
interface add_sub_lanes_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] a;
    logic [LANES*WIDTH-1:0] b;
    logic                   sub;
    logic                   is_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] result;
    logic [LANES-1:0]       carry_or_borrow;
    logic [LANES-1:0]       overflow;
    logic                   busy;

    modport master (
        output in_valid, a, b, sub, is_signed, out_ready,
        input  in_ready, out_valid, result, carry_or_borrow, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, sub, is_signed, out_ready,
        output in_ready, out_valid, result, carry_or_borrow, overflow, busy
    );
endinterface

// File: rtl/add_sub_lanes.sv
// add_sub_lanes: two-stage elastic multi-lane add/subtract with per-lane carry/borrow and overflow; define ADD_SUB_SAT_EN for saturating results
module add_sub_lanes #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input logic            clk,
    input logic            rst,
    add_sub_lanes_if.slave bus
);
    localparam int LW = LANES * WIDTH;

    logic            v1_q, v2_q;
    logic [LW-1:0]   a1_q, b1_q;
    logic            sub1_q, sgn1_q;
    logic [LW-1:0]   res_d, res_q;
    logic [LANES-1:0] cb_d, cb_q, ov_d, ov_q;
    logic            rdy1, rdy2;

    assign rdy2 = !v2_q || bus.out_ready;
    assign rdy1 = !v1_q || rdy2;

    assign bus.in_ready        = rdy1;
    assign bus.out_valid       = v2_q;
    assign bus.result          = res_q;
    assign bus.carry_or_borrow = cb_q;
    assign bus.overflow        = ov_q;
    assign bus.busy            = v1_q || v2_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] la, lbx, raw;
        logic [WIDTH:0]   s;
        logic             cb, sov;
        assign la  = a1_q[i*WIDTH +: WIDTH];
        assign lbx = sub1_q ? ~b1_q[i*WIDTH +: WIDTH] : b1_q[i*WIDTH +: WIDTH];
        assign s   = {1'b0, la} + {1'b0, lbx} + {{WIDTH{1'b0}}, sub1_q};
        assign raw = s[WIDTH-1:0];
        // subtraction reports borrow, which is the inverted carry of a + ~b + 1
        assign cb  = s[WIDTH] ^ sub1_q;
        // overflow direction always follows the sign of a, which the saturation value reuses
        assign sov = (la[WIDTH-1] == lbx[WIDTH-1]) && (raw[WIDTH-1] != la[WIDTH-1]);
        assign cb_d[i] = cb;
        assign ov_d[i] = sgn1_q ? sov : cb;
`ifdef ADD_SUB_SAT_EN
        logic [WIDTH-1:0] sat;
        assign sat = sgn1_q ? (la[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                            : {WIDTH{!sub1_q}};
        assign res_d[i*WIDTH +: WIDTH] = ov_d[i] ? sat : raw;
`else
        assign res_d[i*WIDTH +: WIDTH] = raw;
`endif
    end

    // S1: capture operands and op whenever the stage is free or draining
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            sub1_q <= 1'b0;
            sgn1_q <= 1'b0;
        end else if (rdy1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                a1_q   <= bus.a;
                b1_q   <= bus.b;
                sub1_q <= bus.sub;
                sgn1_q <= bus.is_signed;
            end
        end
    end

    // S2: register results and flags; held stable while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            res_q <= '0;
            cb_q  <= '0;
            ov_q  <= '0;
        end else if (rdy2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                res_q <= res_d;
                cb_q  <= cb_d;
                ov_q  <= ov_d;
            end
        end
    end
endmodule

// File: tb/tb_add_sub_lanes.sv
// tb_add_sub_lanes: directed and randomized checks of add_sub_lanes against an integer-arithmetic reference model
module tb_add_sub_lanes;
    localparam int W  = 8;
    localparam int L  = 4;
    localparam int LW = W * L;
    localparam int M  = 1 << W;

    typedef struct {
        logic [LW-1:0] res;
        logic [L-1:0]  cb;
        logic [L-1:0]  ov;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_sub_lanes_if #(.WIDTH(W), .LANES(L)) bus ();
    add_sub_lanes #(.WIDTH(W), .LANES(L)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    exp_t q[$];
    exp_t mon_e;
    int n_chk = 0, n_err = 0, cyc = 0, run = 0, peak = 0;
    bit chk_lat = 1'b1, head_seen = 1'b0, prev_stall = 1'b0, saw_stall = 1'b0, done = 1'b0;
    logic [LW-1:0] prev_res;
    logic [L-1:0]  prev_cb, prev_ov;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [LW-1:0] a, input logic [LW-1:0] b, input logic s, input logic g);
        exp_t e;
        logic [W-1:0] av, bv;
        int ua, ub, sa, sb, ur, sr, r;
        bit cb, sov;
        e.res = '0; e.cb = '0; e.ov = '0; e.cyc = 0;
        for (int i = 0; i < L; i++) begin
            av = a[i*W +: W];
            bv = b[i*W +: W];
            ua = int'(av);
            ub = int'(bv);
            sa = ua >= M / 2 ? ua - M : ua;
            sb = ub >= M / 2 ? ub - M : ub;
            ur = s ? ua - ub : ua + ub;
            sr = s ? sa - sb : sa + sb;
            cb = s ? (ua < ub) : (ur >= M);
            sov = (sr > M / 2 - 1) || (sr < -(M / 2));
            r = ((ur % M) + M) % M;
`ifdef ADD_SUB_SAT_EN
            if (g && sov) r = sr > 0 ? M / 2 - 1 : M / 2;
            else if (!g && cb) r = s ? 0 : M - 1;
`endif
            e.res[i*W +: W] = r[W-1:0];
            e.cb[i] = cb;
            e.ov[i] = g ? sov : cb;
        end
        return e;
    endfunction

    // scoreboard: records accepted beats, checks every delivered beat, stall stability and latency
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            head_seen = 1'b0;
            prev_stall = 1'b0;
            run = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_result", 64'(bus.result), 64'(prev_res));
                check("hold_cb", 64'(bus.carry_or_borrow), 64'(prev_cb));
                check("hold_ov", 64'(bus.overflow), 64'(prev_ov));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res = bus.result;
            prev_cb = bus.carry_or_borrow;
            prev_ov = bus.overflow;
            run = bus.out_valid ? run + 1 : 0;
            if (run > peak) peak = run;
            if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
            if (bus.out_valid && q.size() == 0) begin
                check("spurious_out", 64'(1), 64'(0));
            end else if (bus.out_valid) begin
                if (!head_seen && chk_lat) check("latency", 64'(cyc - q[0].cyc), 64'(2));
                head_seen = 1'b1;
                if (bus.out_ready) begin
                    mon_e = q.pop_front();
                    head_seen = 1'b0;
                    check("result", 64'(bus.result), 64'(mon_e.res));
                    check("carry_or_borrow", 64'(bus.carry_or_borrow), 64'(mon_e.cb));
                    check("overflow", 64'(bus.overflow), 64'(mon_e.ov));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                mon_e = model(bus.a, bus.b, bus.sub, bus.is_signed);
                mon_e.cyc = cyc;
                q.push_back(mon_e);
            end
        end
    end

    task automatic send(input logic [LW-1:0] a_v, input logic [LW-1:0] b_v, input logic s, input logic g);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.a = a_v;
        bus.b = b_v;
        bus.sub = s;
        bus.is_signed = g;
        @(negedge clk);
        while (!bus.in_ready && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (k >= 200) check("send_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [LW-1:0] r, input logic [L-1:0] c, input logic [L-1:0] o);
        int k = 0;
        while (!bus.out_valid && k < 20) begin
            k++;
            @(negedge clk);
        end
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_result"}, 64'(bus.result), 64'(r));
        check({tag, "_cb"}, 64'(bus.carry_or_borrow), 64'(c));
        check({tag, "_ov"}, 64'(bus.overflow), 64'(o));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (q.size() != 0 && k < 100) begin
            k++;
            @(negedge clk);
        end
        check(tag, 64'(q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_result", 64'(bus.result), 64'(0));
        check("rst_cb", 64'(bus.carry_or_borrow), 64'(0));
        check("rst_ov", 64'(bus.overflow), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(32'h0080FF15, 32'h00800110, 1'b0, 1'b0);
        expect_out("uadd", 32'h00000025, 4'b0110, 4'b0110);

`ifdef ADD_SUB_SAT_EN
        send(32'hFF000514, 32'hFF010A05, 1'b1, 1'b0);
        expect_out("usub", 32'h0000000F, 4'b0110, 4'b0110);
        send(32'hFF40807F, 32'h0140FF01, 1'b0, 1'b1);
        expect_out("sadd", 32'h007F807F, 4'b1010, 4'b0111);
`else
        send(32'hFF000514, 32'hFF010A05, 1'b1, 1'b0);
        expect_out("usub", 32'h00FFFB0F, 4'b0110, 4'b0110);
        send(32'hFF40807F, 32'h0140FF01, 1'b0, 1'b1);
        expect_out("sadd", 32'h00807F80, 4'b1010, 4'b0111);
`endif

        chk_lat = 1'b0;
        saw_stall = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_stalled", 64'(saw_stall), 64'(1));

        chk_lat = 1'b1;
        send(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        send(32'h33333333, 32'h44444444, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_mid_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid_queue", 64'(q.size()), 64'(0));
        e = model(32'h05807F01, 32'h0301FE02, 1'b1, 1'b1);
        send(32'h05807F01, 32'h0301FE02, 1'b1, 1'b1);
        expect_out("post_rst", e.res, e.cb, e.ov);

        peak = 0;
        for (int i = 0; i < 16; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
        drain("tput_drain");
        repeat (2) @(posedge clk);
        #1;
        check("tput_run", 64'(peak), 64'(16));

        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send($urandom, $urandom, 1'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #1 bus.out_ready = $urandom_range(0, 3) != 0;
            end
        join
        bus.out_ready = 1'b1;
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
